// File: rtl/fetch_wait_stage_pkg.sv
// fetch_wait_stage_pkg
//   Shared definitions for the IF_wait stage:
//   - EXC_* exception codes carried in the fetch bundle
//   - BUNDLE_W: packed width of one {pc, inst, exc, exc_miss, exccode} bundle
//   - bundle_t: field view of a stored bundle
package fetch_wait_stage_pkg;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_MOD  = 5'h01;
  localparam logic [4:0] EXC_TLBL = 5'h02;
  localparam logic [4:0] EXC_TLBS = 5'h03;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;

  localparam int BUNDLE_W = 32 + 32 + 1 + 1 + 5;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
    logic        exc_miss;
    logic [4:0]  exccode;
  } bundle_t;

endpackage

// File: rtl/fetch_resp_fifo.sv
// fetch_resp_fifo
//   Two-entry synchronous FIFO holding fetch bundles for decode.
//   Ports:
//     clk, resetn  clock, asynchronous active-low reset (control only)
//     push, din    write din at the tail
//     pop          drop the head entry
//     flush        empty the FIFO; overrides push and pop
//     dout         head entry (meaningful only while count != 0)
//     count        number of valid entries (0..2)
module fetch_resp_fifo
  import fetch_wait_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                push,
  input  logic                pop,
  input  logic                flush,
  input  logic [BUNDLE_W-1:0] din,
  output logic [BUNDLE_W-1:0] dout,
  output logic [1:0]          count
);

  logic [BUNDLE_W-1:0] mem [DEPTH];
  logic                head;
  logic                tail;

  // Pointers wrap naturally as single bits because the depth is two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
    end else if (flush) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) tail <= ~tail;
      if (pop)  head <= ~head;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Storage is data only; its reset value is never observed because the
  // stage masks outputs with count != 0.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[tail] <= din;
  end

  assign dout = mem[head];

endmodule

// File: rtl/fetch_wait_stage.sv
// fetch_wait_stage
//   IF_wait stage: waits for the instruction bus response of the entry held
//   by fetch, discards responses of cancelled entries and hands in-order
//   {pc, inst, exception} bundles to decode via a 2-entry FIFO.
//   Ports:
//     inst_data_ok, inst_rdata          bus read response
//     valid_i, pc_i, cancelled_i,
//     exc_i, exc_miss_i, exccode_i      entry registered by fetch
//     ready_o                           fetch may replace its entry
//     valid_o, pc_o, inst_o, exc_o,
//     exc_miss_o, exccode_o, ready_i    decode-side bundle handshake
//     cancel_i                          pipeline flush
//     perfcnt_fetch_waitdata            cycles a live entry waits for data
module fetch_wait_stage
  import fetch_wait_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        valid_i,
  input  logic [31:0] pc_i,
  input  logic        cancelled_i,
  input  logic        exc_i,
  input  logic        exc_miss_i,
  input  logic [4:0]  exccode_i,
  output logic        ready_o,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        exc_o,
  output logic        exc_miss_o,
  output logic [4:0]  exccode_o,
  input  logic        ready_i,
  input  logic        cancel_i,
  output logic [31:0] perfcnt_fetch_waitdata
);

  logic                resolved;
  logic                drop;
  logic                push;
  logic                pop;
  logic                drop_pend;
  logic [1:0]          count;
  logic [1:0]          count_next;
  logic [BUNDLE_W-1:0] push_data;
  logic [BUNDLE_W-1:0] head_data;
  bundle_t             head_b;

  assign resolved = valid_i && (exc_i || inst_data_ok);
  // drop_pend covers a flush that hit while the response was still in flight.
  assign drop     = cancelled_i || drop_pend || cancel_i;
  assign push     = resolved && !drop;
  assign pop      = valid_o && ready_i && !cancel_i;

  assign push_data = {pc_i, (exc_i ? 32'd0 : inst_rdata), exc_i, exc_miss_i, exccode_i};

  // Flush-adjusted occupancy; fetch is only released when a slot is
  // guaranteed for the response of its next entry, since data cannot stall.
  assign count_next = cancel_i ? 2'd0 : (count + {1'b0, push} - {1'b0, pop});
  assign ready_o    = (!valid_i || resolved) && (count_next <= 2'd1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      drop_pend <= 1'b0;
    end else if (resolved) begin
      drop_pend <= 1'b0;
    end else if (cancel_i && valid_i) begin
      drop_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perfcnt_fetch_waitdata <= 32'd0;
    end else if (valid_i && !exc_i && !drop && !inst_data_ok) begin
      perfcnt_fetch_waitdata <= perfcnt_fetch_waitdata + 32'd1;
    end
  end

  // ---- response -> decode boundary: bundles are registered in the FIFO ----
  fetch_resp_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .flush  (cancel_i),
    .din    (push_data),
    .dout   (head_data),
    .count  (count)
  );

  assign head_b  = head_data;
  assign valid_o = (count != 2'd0);

  // Masking with valid_o gives zero outputs while empty and during reset.
  assign pc_o       = valid_o ? head_b.pc       : 32'd0;
  assign inst_o     = valid_o ? head_b.inst     : 32'd0;
  assign exc_o      = valid_o ? head_b.exc      : 1'b0;
  assign exc_miss_o = valid_o ? head_b.exc_miss : 1'b0;
  assign exccode_o  = valid_o ? head_b.exccode  : 5'd0;

endmodule

// File: tb/tb_fetch_wait_stage.sv
module tb_fetch_wait_stage;
  import fetch_wait_stage_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        valid_i;
  logic [31:0] pc_i;
  logic        cancelled_i;
  logic        exc_i;
  logic        exc_miss_i;
  logic [4:0]  exccode_i;
  logic        ready_o;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        exc_o;
  logic        exc_miss_o;
  logic [4:0]  exccode_o;
  logic        ready_i;
  logic        cancel_i;
  logic [31:0] perfcnt_fetch_waitdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fetch_wait_stage #(.DEPTH(2)) dut (
    .clk                    (clk),
    .resetn                 (resetn),
    .inst_data_ok           (inst_data_ok),
    .inst_rdata             (inst_rdata),
    .valid_i                (valid_i),
    .pc_i                   (pc_i),
    .cancelled_i            (cancelled_i),
    .exc_i                  (exc_i),
    .exc_miss_i             (exc_miss_i),
    .exccode_i              (exccode_i),
    .ready_o                (ready_o),
    .valid_o                (valid_o),
    .pc_o                   (pc_o),
    .inst_o                 (inst_o),
    .exc_o                  (exc_o),
    .exc_miss_o             (exc_miss_o),
    .exccode_o              (exccode_o),
    .ready_i                (ready_i),
    .cancel_i               (cancel_i),
    .perfcnt_fetch_waitdata (perfcnt_fetch_waitdata)
  );

  // Bus protocol: a response only ever answers a live, non-exception entry.
  always @(posedge clk) begin
    if (resetn === 1'b1)
      assert (!(inst_data_ok && (!valid_i || exc_i)))
        else $error("protocol: inst_data_ok without a waiting entry");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs change.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_i      = 1'b0;
    pc_i         = 32'd0;
    inst_data_ok = 1'b0;
    inst_rdata   = 32'd0;
    cancelled_i  = 1'b0;
    exc_i        = 1'b0;
    exc_miss_i   = 1'b0;
    exccode_i    = 5'd0;
    cancel_i     = 1'b0;
  endtask

  task automatic entry(input logic [31:0] pc, input logic dok, input logic [31:0] rdata);
    valid_i      = 1'b1;
    pc_i         = pc;
    inst_data_ok = dok;
    inst_rdata   = rdata;
  endtask

  initial begin
    idle_inputs();
    ready_i = 1'b1;
    resetn  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid_o", {31'd0, valid_o}, 32'd0);
    check("rst_pc_o", pc_o, 32'd0);
    check("rst_perfcnt", perfcnt_fetch_waitdata, 32'd0);
    check("rst_ready_o", {31'd0, ready_o}, 32'd1);
    resetn = 1'b1;

    // Single fetch: three wait cycles, then the response.
    for (int i = 0; i < 3; i++) begin
      if (i != 0) next_cycle();
      entry(32'hBFC0_0000, 1'b0, 32'd0);
      @(negedge clk);
      if (i == 0) check("single_wait_ready_o", {31'd0, ready_o}, 32'd0);
    end
    next_cycle();
    entry(32'hBFC0_0000, 1'b1, 32'h3C1D_8000);
    @(negedge clk);
    check("single_dok_ready_o", {31'd0, ready_o}, 32'd1);
    check("single_dok_valid_o", {31'd0, valid_o}, 32'd0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("single_valid_o", {31'd0, valid_o}, 32'd1);
    check("single_pc_o", pc_o, 32'hBFC0_0000);
    check("single_inst_o", inst_o, 32'h3C1D_8000);
    check("single_perfcnt", perfcnt_fetch_waitdata, 32'd3);

    // Decode stall: FIFO fills to two, then drains in order.
    next_cycle();
    ready_i = 1'b0;
    entry(32'h0000_0000, 1'b1, 32'hA000_0000);
    @(negedge clk);
    check("stall_push1_ready_o", {31'd0, ready_o}, 32'd1);
    next_cycle();
    entry(32'h0000_0004, 1'b1, 32'hA000_0004);
    @(negedge clk);
    check("stall_push2_ready_o", {31'd0, ready_o}, 32'd0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("stall_full_ready_o", {31'd0, ready_o}, 32'd0);
    check("stall_full_pc_o", pc_o, 32'h0000_0000);
    next_cycle();
    ready_i = 1'b1;
    entry(32'h0000_0008, 1'b1, 32'hA000_0008);
    @(negedge clk);
    check("stall_out0_pc_o", pc_o, 32'h0000_0000);
    check("stall_out0_inst_o", inst_o, 32'hA000_0000);
    check("stall_pushpop_ready_o", {31'd0, ready_o}, 32'd0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("stall_out1_pc_o", pc_o, 32'h0000_0004);
    check("stall_out1_inst_o", inst_o, 32'hA000_0004);
    next_cycle();
    @(negedge clk);
    check("stall_out2_pc_o", pc_o, 32'h0000_0008);
    check("stall_out2_inst_o", inst_o, 32'hA000_0008);
    next_cycle();
    @(negedge clk);
    check("stall_empty_valid_o", {31'd0, valid_o}, 32'd0);
    check("stall_perfcnt", perfcnt_fetch_waitdata, 32'd3);

    // Exception entry resolves without a bus response.
    next_cycle();
    entry(32'h8000_0002, 1'b0, 32'h1234_5678);
    exc_i      = 1'b1;
    exc_miss_i = 1'b1;
    exccode_i  = EXC_ADEL;
    @(negedge clk);
    check("exc_ready_o", {31'd0, ready_o}, 32'd1);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("exc_valid_o", {31'd0, valid_o}, 32'd1);
    check("exc_pc_o", pc_o, 32'h8000_0002);
    check("exc_inst_o", inst_o, 32'd0);
    check("exc_exc_o", {31'd0, exc_o}, 32'd1);
    check("exc_miss_o", {31'd0, exc_miss_o}, 32'd1);
    check("exc_exccode_o", {27'd0, exccode_o}, {27'd0, EXC_ADEL});
    check("exc_perfcnt", perfcnt_fetch_waitdata, 32'd3);

    // Flush while an entry waits: its late response must vanish.
    next_cycle();
    ready_i = 1'b0;
    entry(32'h0000_0FFC, 1'b1, 32'hCAFE_0000);
    next_cycle();
    entry(32'h0000_1000, 1'b0, 32'd0);
    @(negedge clk);
    check("flush_pre_valid_o", {31'd0, valid_o}, 32'd1);
    next_cycle();
    cancel_i = 1'b1;
    @(negedge clk);
    check("flush_cancel_ready_o", {31'd0, ready_o}, 32'd0);
    next_cycle();
    cancel_i = 1'b0;
    @(negedge clk);
    check("flush_empty_valid_o", {31'd0, valid_o}, 32'd0);
    check("flush_wait_ready_o", {31'd0, ready_o}, 32'd0);
    next_cycle();
    entry(32'h0000_1000, 1'b1, 32'hDEAD_BEEF);
    @(negedge clk);
    check("flush_dok_ready_o", {31'd0, ready_o}, 32'd1);
    next_cycle();
    ready_i = 1'b1;
    entry(32'h0000_2000, 1'b1, 32'h1111_1111);
    @(negedge clk);
    check("flush_dropped_valid_o", {31'd0, valid_o}, 32'd0);
    check("flush_perfcnt", perfcnt_fetch_waitdata, 32'd4);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("flush_next_valid_o", {31'd0, valid_o}, 32'd1);
    check("flush_next_pc_o", pc_o, 32'h0000_2000);
    check("flush_next_inst_o", inst_o, 32'h1111_1111);

    // cancelled_i entry dropped, following entry delivered.
    next_cycle();
    entry(32'h0000_3000, 1'b1, 32'hAAAA_0000);
    cancelled_i = 1'b1;
    @(negedge clk);
    check("cxl_ready_o", {31'd0, ready_o}, 32'd1);
    next_cycle();
    cancelled_i = 1'b0;
    entry(32'h0000_3004, 1'b1, 32'hBBBB_0000);
    @(negedge clk);
    check("cxl_dropped_valid_o", {31'd0, valid_o}, 32'd0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("cxl_next_pc_o", pc_o, 32'h0000_3004);
    check("cxl_next_inst_o", inst_o, 32'hBBBB_0000);

    // cancel_i together with data_ok: dropped, no lingering drop_pend.
    next_cycle();
    entry(32'h0000_4000, 1'b1, 32'hCCCC_0000);
    cancel_i = 1'b1;
    @(negedge clk);
    check("samecyc_ready_o", {31'd0, ready_o}, 32'd1);
    next_cycle();
    cancel_i = 1'b0;
    entry(32'h0000_4004, 1'b1, 32'hDDDD_0000);
    @(negedge clk);
    check("samecyc_dropped_valid_o", {31'd0, valid_o}, 32'd0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("samecyc_next_valid_o", {31'd0, valid_o}, 32'd1);
    check("samecyc_next_pc_o", pc_o, 32'h0000_4004);
    check("samecyc_next_inst_o", inst_o, 32'hDDDD_0000);

    // Async reset with a full FIFO and an entry waiting.
    next_cycle();
    ready_i = 1'b0;
    entry(32'h0000_5000, 1'b1, 32'hE000_0000);
    next_cycle();
    entry(32'h0000_5004, 1'b1, 32'hE000_0004);
    next_cycle();
    entry(32'h0000_5008, 1'b0, 32'd0);
    @(negedge clk);
    check("arst_pre_valid_o", {31'd0, valid_o}, 32'd1);
    check("arst_pre_perfcnt", perfcnt_fetch_waitdata, 32'd4);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_valid_o", {31'd0, valid_o}, 32'd0);
    check("arst_pc_o", pc_o, 32'd0);
    check("arst_inst_o", inst_o, 32'd0);
    check("arst_perfcnt", perfcnt_fetch_waitdata, 32'd0);
    next_cycle();
    idle_inputs();
    resetn = 1'b1;
    @(negedge clk);
    check("post_rst_valid_o", {31'd0, valid_o}, 32'd0);
    check("post_rst_perfcnt", perfcnt_fetch_waitdata, 32'd0);
    check("post_rst_ready_o", {31'd0, ready_o}, 32'd1);
    next_cycle();
    @(negedge clk);
    check("post_rst_idle_valid_o", {31'd0, valid_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog: the directed sequence is a few hundred ns long.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
